// File: rtl/coriolis_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coriolis_stream_pkg
// Description : Shared widths and FSM encoding for the coriolis output stream
//               collector and its FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package coriolis_stream_pkg;

  // Default kernel stream word width and packed un/vn pair width
  localparam int C_STREAMW = 34;
  localparam int C_PAIRW   = 2 * C_STREAMW;

  // Collector run-control states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } cor_state_e;

endpackage
`default_nettype wire

// File: rtl/coriolis_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : coriolis_sync_fifo
// Description : First-word-fall-through synchronous FIFO with registered
//               storage. Writes are dropped when full and reads are ignored
//               when empty. rdata is forced to zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module coriolis_sync_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int C_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int C_OW = C_AW + 1;
  localparam logic [C_OW-1:0] C_DEPTH = C_OW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [C_AW-1:0]  wptr_q;
  logic [C_AW-1:0]  rptr_q;
  logic [C_OW-1:0]  occ_q;
  logic             w_do_wr;
  logic             w_do_rd;

  assign full    = (occ_q == C_DEPTH);
  assign empty   = (occ_q == '0);
  // A full FIFO never accepts a write, even when a read frees a slot this cycle
  assign w_do_wr = wr & ~full;
  assign w_do_rd = rd & ~empty;
  assign rdata   = empty ? '0 : mem_q[rptr_q];

  // Storage array: no reset needed, contents are only visible while occupied
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; occupancy tracks the fill level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (w_do_wr) wptr_q <= wptr_q + 1'b1;
      if (w_do_rd) rptr_q <= rptr_q + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/coriolis_ostream_collect.sv
`default_nettype none
// ============================================================================
// Module      : coriolis_ostream_collect
// Description : Collects the coriolis kernel's paired un/vn output streams,
//               packs each pair as {vn, un} into a small FWFT FIFO toward the
//               memory writer, and tracks a run of NELEM pairs.
//               Optional macro COR_OSTREAM_STATS_EN adds the stall_cnt port.
// Revision    : 1.0 - initial release
// ============================================================================
module coriolis_ostream_collect
  import coriolis_stream_pkg::*;
#(
  parameter int STREAMW = C_STREAMW,
  parameter int DEPTH   = 4,
  parameter int NELEM   = 1024,
  parameter int CNTW    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 ivalid,
  input  logic [STREAMW-1:0]   un_s0,
  input  logic [STREAMW-1:0]   vn_s0,
  output logic                 oready_un_s0,
  output logic                 oready_vn_s0,
  output logic [2*STREAMW-1:0] odata,
  output logic                 ovalid,
  input  logic                 oready,
  output logic                 busy,
  output logic                 done,
`ifdef COR_OSTREAM_STATS_EN
  output logic [CNTW-1:0]      stall_cnt,
`endif
  output logic [CNTW-1:0]      count
);

  localparam logic [CNTW-1:0] C_NELEM = CNTW'(NELEM);
  localparam logic [CNTW-1:0] C_LAST  = CNTW'(NELEM - 1);

  cor_state_e      state_q;
  logic [CNTW-1:0] in_cnt_q;
  logic [CNTW-1:0] in_cnt_d;
  logic [CNTW-1:0] count_q;
  logic [CNTW-1:0] count_d;
  logic            w_full;
  logic            w_empty;
  logic            w_ready;
  logic            w_accept;
  logic            w_read;
  logic            w_start;

  // Ready depends only on registered state and occupancy
  assign w_ready      = (state_q == S_RUN) & ~w_full;
  assign oready_un_s0 = w_ready;
  assign oready_vn_s0 = w_ready;
  assign w_accept     = ivalid & w_ready;
  assign ovalid       = ~w_empty;
  assign w_read       = ~w_empty & oready;
  assign w_start      = start & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign busy         = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);
  assign count        = count_q;

  coriolis_sync_fifo #(
    .WIDTH (2 * STREAMW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (w_accept),
    .wdata ({vn_s0, un_s0}),
    .rd    (w_read),
    .rdata (odata),
    .full  (w_full),
    .empty (w_empty)
  );

  // Element counters: cleared on an accepted start, saturating at NELEM
  always_comb begin
    in_cnt_d = in_cnt_q;
    count_d  = count_q;
    if (w_start) begin
      in_cnt_d = '0;
      count_d  = '0;
    end else begin
      if (w_accept && (in_cnt_q != C_NELEM)) in_cnt_d = in_cnt_q + 1'b1;
      if (w_read && (count_q != C_NELEM))    count_d  = count_q + 1'b1;
    end
  end

  // Run-control FSM and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      in_cnt_q <= '0;
      count_q  <= '0;
    end else begin
      in_cnt_q <= in_cnt_d;
      count_q  <= count_d;
      case (state_q)
        S_IDLE, S_DONE: if (start) state_q <= S_RUN;
        S_RUN:          if (w_accept && (in_cnt_q == C_LAST)) state_q <= S_DRAIN;
        S_DRAIN:        if (w_read && (count_q == C_LAST)) state_q <= S_DONE;
        default:        state_q <= S_IDLE;
      endcase
    end
  end

`ifdef COR_OSTREAM_STATS_EN
  logic [CNTW-1:0] stall_q;

  // Backpressure cycles seen while a run is active, saturating at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (w_start) begin
      stall_q <= '0;
    end else if (busy && ovalid && !oready && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_coriolis_ostream_collect.sv
`default_nettype none
// ============================================================================
// Module      : tb_coriolis_ostream_collect
// Description : Self-checking bench for coriolis_ostream_collect. Two
//               instances (NELEM=4 and NELEM=8, DEPTH=4) share the stimulus;
//               sel chooses which one the checks observe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coriolis_ostream_collect;

  localparam int SW = 34;
  localparam int PW = 2 * SW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          ivalid;
  logic [SW-1:0] un;
  logic [SW-1:0] vn;
  logic          oready;

  logic          rdy_un4, rdy_vn4, ov4, busy4, done4;
  logic [PW-1:0] od4;
  logic [31:0]   cnt4;
  logic          rdy_un8, rdy_vn8, ov8, busy8, done8;
  logic [PW-1:0] od8;
  logic [31:0]   cnt8;
`ifdef COR_OSTREAM_STATS_EN
  logic [31:0]   stall4;
  logic [31:0]   stall8;
`endif

  logic          sel;
  logic          m_ready, m_ready_vn, m_ovalid, m_busy, m_done;
  logic [PW-1:0] m_odata;
  logic [31:0]   m_count;

  int checks = 0;
  int errors = 0;
  int acc_idx;
  int out_idx;

  always #5 clk = ~clk;

  coriolis_ostream_collect #(.STREAMW(SW), .DEPTH(4), .NELEM(4), .CNTW(32)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .ivalid(ivalid), .un_s0(un), .vn_s0(vn),
    .oready_un_s0(rdy_un4), .oready_vn_s0(rdy_vn4), .odata(od4), .ovalid(ov4),
    .oready(oready), .busy(busy4), .done(done4),
`ifdef COR_OSTREAM_STATS_EN
    .stall_cnt(stall4),
`endif
    .count(cnt4)
  );

  coriolis_ostream_collect #(.STREAMW(SW), .DEPTH(4), .NELEM(8), .CNTW(32)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .ivalid(ivalid), .un_s0(un), .vn_s0(vn),
    .oready_un_s0(rdy_un8), .oready_vn_s0(rdy_vn8), .odata(od8), .ovalid(ov8),
    .oready(oready), .busy(busy8), .done(done8),
`ifdef COR_OSTREAM_STATS_EN
    .stall_cnt(stall8),
`endif
    .count(cnt8)
  );

  assign m_ready    = sel ? rdy_un8 : rdy_un4;
  assign m_ready_vn = sel ? rdy_vn8 : rdy_vn4;
  assign m_ovalid   = sel ? ov8     : ov4;
  assign m_odata    = sel ? od8     : od4;
  assign m_busy     = sel ? busy8   : busy4;
  assign m_done     = sel ? done8   : done4;
  assign m_count    = sel ? cnt8    : cnt4;

  typedef struct {
    logic       start;
    logic       ivalid;
    logic [7:0] un;
    logic [7:0] vn;
    logic       oready;
    logic       e_ready;
    logic       e_ovalid;
    logic [7:0] e_un;
    logic [7:0] e_vn;
    logic [7:0] e_count;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; ivalid = 1'b0; oready = 1'b0; un = '0; vn = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Stream pairs acc_idx.. into the selected DUT with oready high, checking
  // every emitted word in order, until done or the cycle budget runs out.
  task automatic stream(input int n, input int budget);
    int  cyc;
    logic acc_now;
    cyc = 0;
    oready = 1'b1;
    while (!m_done && cyc < budget) begin
      ivalid = (acc_idx < n);
      un = SW'(acc_idx + 1);
      vn = SW'(acc_idx + 'h11);
      @(negedge clk);
      acc_now = m_ready & ivalid;
      if (m_ovalid) begin
        check("stream_odata", m_odata, {SW'(out_idx + 'h11), SW'(out_idx + 1)});
        out_idx++;
      end
      @(posedge clk); #1;
      if (acc_now) acc_idx++;
      cyc++;
    end
    ivalid = 1'b0;
    check("stream_npairs", out_idx, n);
    check("stream_count", m_count, n);
    check("stream_done", m_done, 1'b1);
    check("stream_busy", m_busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    sel = 1'b0;
    // Reset state with random inputs
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = 1'($urandom); ivalid = 1'($urandom); oready = 1'($urandom);
      un = SW'($urandom); vn = SW'($urandom);
      @(negedge clk);
      check("rst_outs4", {rdy_un4, rdy_vn4, od4, ov4, busy4, done4, cnt4}, '0);
      check("rst_outs8", {rdy_un8, rdy_vn8, od8, ov8, busy8, done8, cnt8}, '0);
    end
    start = 1'b0; ivalid = 1'b1; oready = 1'b1;
    #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("post_rst_idle", {rdy_un4, rdy_vn4, busy4, done4, rdy_un8, busy8}, '0);

    // Table-driven run of 4 pairs on the NELEM=4 instance
    vecs[0] = '{1, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'd0, 0, 0};
    vecs[1] = '{0, 1, 8'h01, 8'h11, 1, 1, 0, 8'h00, 8'h00, 8'd0, 1, 0};
    vecs[2] = '{0, 1, 8'h02, 8'h12, 1, 1, 1, 8'h01, 8'h11, 8'd0, 1, 0};
    vecs[3] = '{0, 1, 8'h03, 8'h13, 1, 1, 1, 8'h02, 8'h12, 8'd1, 1, 0};
    vecs[4] = '{0, 1, 8'h04, 8'h14, 1, 1, 1, 8'h03, 8'h13, 8'd2, 1, 0};
    vecs[5] = '{0, 1, 8'h05, 8'h15, 1, 0, 1, 8'h04, 8'h14, 8'd3, 1, 0};
    vecs[6] = '{0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'd4, 0, 1};
    vecs[7] = '{0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'd4, 0, 1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      start = vecs[i].start; ivalid = vecs[i].ivalid; oready = vecs[i].oready;
      un = SW'(vecs[i].un); vn = SW'(vecs[i].vn);
      @(negedge clk);
      check($sformatf("v%0d_ready", i), m_ready, vecs[i].e_ready);
      check($sformatf("v%0d_ready_vn", i), m_ready_vn, vecs[i].e_ready);
      check($sformatf("v%0d_ovalid", i), m_ovalid, vecs[i].e_ovalid);
      check($sformatf("v%0d_odata", i), m_odata, {SW'(vecs[i].e_vn), SW'(vecs[i].e_un)});
      check($sformatf("v%0d_count", i), m_count, 32'(vecs[i].e_count));
      check($sformatf("v%0d_busy", i), m_busy, vecs[i].e_busy);
      check($sformatf("v%0d_done", i), m_done, vecs[i].e_done);
      @(posedge clk); #1;
    end

    // Fill the FIFO under backpressure on the NELEM=8 instance, then drain
    sel = 1'b1;
    do_reset();
    do_start();
    acc_idx = 0; out_idx = 0;
    oready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic acc_now;
      ivalid = 1'b1; un = SW'(acc_idx + 1); vn = SW'(acc_idx + 'h11);
      @(negedge clk);
      acc_now = m_ready;
      @(posedge clk); #1;
      if (acc_now) acc_idx++;
    end
    check("fill_accepts", acc_idx, 4);
    check("fill_ready", m_ready, 1'b0);
    check("fill_ovalid", m_ovalid, 1'b1);
    check("fill_odata", m_odata, {SW'('h11), SW'(1)});
    // Full FIFO with read and offered write in the same cycle: read only
    oready = 1'b1; ivalid = 1'b1; un = SW'(5); vn = SW'('h15);
    @(negedge clk);
    check("full_rd_ready", m_ready, 1'b0);
    check("full_rd_odata", m_odata, {SW'('h11), SW'(1)});
    out_idx = 1;
    @(posedge clk); #1;
    check("after_full_ready", m_ready, 1'b1);
    check("after_full_count", m_count, 32'd1);
    stream(8, 60);

    // Ignored start mid-run, then reset with a pair still buffered
    sel = 1'b0;
    do_reset();
    do_start();
    oready = 1'b1; ivalid = 1'b1; un = SW'(1); vn = SW'('h11);
    @(posedge clk); #1;
    un = SW'(2); vn = SW'('h12); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ivalid = 1'b0; oready = 1'b0;
    @(negedge clk);
    check("mid_start_count", m_count, 32'd1);
    check("mid_start_busy", m_busy, 1'b1);
    check("mid_start_odata", m_odata, {SW'('h12), SW'(2)});
    rst = 1'b0;
    #1;
    check("async_rst_outs4", {rdy_un4, rdy_vn4, od4, ov4, busy4, done4, cnt4}, '0);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    do_start();
    check("restart_count", m_count, 32'd0);
    acc_idx = 0; out_idx = 0;
    stream(4, 40);

`ifdef COR_OSTREAM_STATS_EN
    // Stall counting while the head word is held back
    do_reset();
    do_start();
    oready = 1'b0; ivalid = 1'b1; un = SW'(1); vn = SW'('h11);
    @(posedge clk); #1;
    ivalid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("stall_cnt5", stall4, 32'd5);
    acc_idx = 1; out_idx = 0;
    stream(4, 40);
    check("stall_hold", stall4, 32'd5);
    do_start();
    check("stall_clear", stall4, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/coriolis_ostream_collect.md
Name: coriolis_ostream_collect

Overview:
- Downstream stage of the coriolis kernel top.
- Consumes the kernel's paired un/vn output streams and returns the kernel's per-output ready signals.
- Packs each un/vn pair into one 2*STREAMW word and buffers it in a small FIFO for the memory-writer stream.
- Counts elements per run; flags completion once NELEM pairs have been delivered downstream.

Parameters:
- STREAMW, 34, width of one stream word (kernel data width).
- DEPTH, 4, FIFO entries; power of 2, >=2.
- NELEM, 1024, pairs per run; must be >=1.
- CNTW, 32, width of element counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a run.
- ivalid  in  1  kernel ovalid (un and vn valid together).
- un_s0  in  STREAMW  kernel un output.
- vn_s0  in  STREAMW  kernel vn output.
- oready_un_s0  out  1  ready to kernel un output.
- oready_vn_s0  out  1  ready to kernel vn output; always equal to oready_un_s0.
- odata  out  2*STREAMW  packed word {vn_s0, un_s0}.
- ovalid  out  1  odata valid.
- oready  in  1  downstream ready.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- count  out  CNTW  pairs delivered downstream in the current run.

Behaviour:
- Reset (rst=0, async):
  - state IDLE; FIFO pointers and occupancy 0; in_cnt=0, count=0.
  - All outputs 0, including odata.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start -> RUN. in_cnt and count cleared on that edge.
  - RUN: accepting. Accept when ivalid & oready_un_s0 (accept = write pair into FIFO). On the accept where in_cnt==NELEM-1, go to DRAIN.
  - DRAIN: no accepts. When the final read happens (count reaches NELEM), go to DONE.
  - DONE: done=1. start -> RUN with counters cleared.
  - start in RUN or DRAIN is ignored.
- oready_un_s0 = oready_vn_s0 = (state==RUN) & !full. Combinational from registered state and occupancy only; never from ivalid or oready.
- FIFO:
  - First-word-fall-through with registered storage.
  - A pair accepted on edge N appears on odata/ovalid after edge N, so latency is 1 cycle when empty.
  - Read = ovalid & oready. odata holds stable while ovalid & !oready.
- Boundary conditions:
  - Full: no write that cycle, even if a read occurs the same cycle (no write-through when full).
  - Empty: ovalid=0.
  - Simultaneous read and write when neither full nor empty: occupancy unchanged.
  - Pointers wrap modulo DEPTH. Occupancy is tracked with a log2(DEPTH)+1-bit counter.
- Counters:
  - in_cnt increments per accept; count increments per read.
  - Both saturate at NELEM; no wrap within a run.
- Reset mid-run: FIFO contents discarded; return to IDLE.

Optional Feature:
- Macro COR_OSTREAM_STATS_EN.
- With the macro defined:
  - Extra output port stall_cnt (CNTW), cleared on start.
  - Increments each cycle in RUN or DRAIN with ovalid & !oready.
  - Saturates at all-ones.
- Without the macro: port and logic absent; all other behaviour identical.

Decomposition:
- Package coriolis_stream_pkg holds:
  - STREAMW default and PAIRW = 2*STREAMW.
  - FSM state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3).
- Sub-module coriolis_sync_fifo:
  - Parameters WIDTH and DEPTH; ports wr/rd/full/empty.
  - Same clk and async active-low rst.
- Top level holds the FSM, counters, ready generation and the optional stats logic.

Test Plan:
1. Hold rst=0 with random inputs -> every output 0, including oready_un_s0/vn. Release rst -> still IDLE, ready low.
2. NELEM=4, oready=1, start, then ivalid=1 with un=0x1..0x4, vn=0x11..0x14:
   - odata = {0x11,0x1} .. {0x14,0x4}, each one cycle after accept.
   - Ready drops after the 4th accept.
   - count=4, then done=1 and busy=0.
3. NELEM=8, DEPTH=4, oready=0, ivalid=1:
   - Exactly 4 accepts, then ready=0 and odata holds {0x11,0x1}.
   - Raise oready -> remaining 4 pairs accepted and emitted in order; count=8.
4. Full FIFO with oready=1 and ivalid=1 in the same cycle -> one read, no write. The write lands the next cycle; no pair lost or duplicated.
5. start pulsed mid-RUN -> ignored, counts continue. Assert rst after 2 of 4 accepts -> outputs 0 immediately, IDLE; a new start runs cleanly from count=0.
6. With COR_OSTREAM_STATS_EN: hold oready=0 for 5 cycles while ovalid=1 -> stall_cnt=5. A following start clears it to 0.
